// File: rtl/pe_sched.sv
// Dot-product scheduler for an 8-lane tree PE: walks the chunk addresses, drains the PE
// pipeline and accumulates the tagged PE results into one neuron sum.
module pe_sched #(
  parameter int unsigned CHUNK_W = 8,
  parameter int unsigned PE_LAT  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CHUNK_W-1:0] cfg_chunks,
  input  logic               stall,
  output logic               busy,
  output logic [CHUNK_W-1:0] in_addr,
  output logic               in_valid,
  output logic [CHUNK_W-1:0] wt_addr,
  output logic               wt_valid,
  output logic               pe_en,
  output logic               pe_clr,
  input  logic [15:0]        pe_out,
  output logic [15:0]        res_data,
  output logic               res_valid,
  input  logic               res_ready
);

  localparam int unsigned DrnW = $clog2(PE_LAT + 1);

  typedef enum logic [2:0] {StIdle, StClear, StIssue, StDrain, StResult} state_e;

  state_e              state_q, state_d;
  logic [CHUNK_W-1:0]  n_q, n_d;
  logic [CHUNK_W-1:0]  k_q, k_d;
  logic [DrnW-1:0]     drn_q, drn_d;
  logic [PE_LAT-1:0]   tag_q, tag_d;
  logic [15:0]         acc_q, acc_d;
  logic [CHUNK_W-1:0]  wt_addr_q;
  logic                wt_valid_q;
  logic                adv;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    k_d       = k_q;
    drn_d     = drn_q;
    tag_d     = tag_q;
    acc_d     = acc_q;
    in_addr   = '0;
    in_valid  = 1'b0;
    pe_en     = 1'b0;
    pe_clr    = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    adv       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && (cfg_chunks != '0)) begin
          n_d     = cfg_chunks;
          k_d     = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        pe_clr  = 1'b1;
        pe_en   = 1'b1;
        acc_d   = '0;
        tag_d   = '0;
        k_d     = '0;
        drn_d   = '0;
        state_d = StIssue;
      end
      StIssue: begin
        // Address stays on the bus through a stall so the buffer read is stable.
        in_addr  = k_q;
        in_valid = 1'b1;
        pe_en    = ~stall;
        adv      = ~stall;
        if (!stall) begin
          if (k_q == n_q - CHUNK_W'(1)) begin
            k_d     = '0;
            state_d = StDrain;
          end else begin
            k_d = k_q + CHUNK_W'(1);
          end
        end
      end
      StDrain: begin
        pe_en = ~stall;
        adv   = ~stall;
        if (!stall) begin
          if (drn_q == DrnW'(PE_LAT - 1)) begin
            drn_d   = '0;
            state_d = StResult;
          end else begin
            drn_d = drn_q + DrnW'(1);
          end
        end
      end
      StResult: begin
        res_valid = 1'b1;
        res_data  = acc_q;
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // The tag pipe mirrors the PE pipeline, so its head marks a real chunk sum on pe_out.
    if (adv) begin
      tag_d = {tag_q[PE_LAT-2:0], in_valid};
      if (tag_q[PE_LAT-1]) acc_d = acc_q + pe_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      n_q        <= '0;
      k_q        <= '0;
      drn_q      <= '0;
      tag_q      <= '0;
      acc_q      <= '0;
      wt_addr_q  <= '0;
      wt_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      drn_q   <= drn_d;
      tag_q   <= tag_d;
      acc_q   <= acc_d;
      if (pe_en) begin
        wt_addr_q  <= in_addr;
        wt_valid_q <= in_valid;
      end
    end
  end

  assign busy     = (state_q != StIdle);
  assign wt_addr  = wt_addr_q;
  assign wt_valid = wt_valid_q;

endmodule

// File: tb/tb_pe_sched.sv
// Directed and randomized jobs for pe_sched against a cycle-timeline model of the schedule
// and a behavioural PE that sums chunk values with a fixed PE_LAT latency.
module tb_pe_sched;

  localparam int unsigned PE_LAT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_chunks;
  logic        stall;
  logic        busy;
  logic [7:0]  in_addr;
  logic        in_valid;
  logic [7:0]  wt_addr;
  logic        wt_valid;
  logic        pe_en;
  logic        pe_clr;
  logic [15:0] pe_out;
  logic [15:0] res_data;
  logic        res_valid;
  logic        res_ready;

  int checks = 0;
  int errors = 0;

  logic [15:0] sums [256];
  logic [15:0] pe_pipe [PE_LAT];

  always #5 clk = ~clk;

  pe_sched #(.CHUNK_W(8), .PE_LAT(PE_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_chunks (cfg_chunks),
    .stall      (stall),
    .busy       (busy),
    .in_addr    (in_addr),
    .in_valid   (in_valid),
    .wt_addr    (wt_addr),
    .wt_valid   (wt_valid),
    .pe_en      (pe_en),
    .pe_clr     (pe_clr),
    .pe_out     (pe_out),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready)
  );

  // Behavioural PE: idle lanes carry random junk that must never reach the sum.
  always @(posedge clk) begin
    if (pe_clr) begin
      for (int i = 0; i < PE_LAT; i++) pe_pipe[i] <= 16'h0;
    end else if (pe_en) begin
      pe_pipe[0] <= in_valid ? sums[in_addr] : 16'($urandom);
      for (int i = 1; i < PE_LAT; i++) pe_pipe[i] <= pe_pipe[i-1];
    end
  end
  assign pe_out = pe_pipe[PE_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_in_addr"}, 32'(in_addr), 32'd0);
    chk({tag, "_in_valid"}, 32'(in_valid), 32'd0);
    chk({tag, "_wt_addr"}, 32'(wt_addr), 32'd0);
    chk({tag, "_wt_valid"}, 32'(wt_valid), 32'd0);
    chk({tag, "_pe_en"}, 32'(pe_en), 32'd0);
    chk({tag, "_pe_clr"}, 32'(pe_clr), 32'd0);
    chk({tag, "_res_data"}, 32'(res_data), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
  endtask

  // One job of n chunks; stall high for cycles [st_from, st_from+st_len), res_ready held low
  // for `hold` result cycles, optional reset asserted at cycle rst_at (0 = none).
  task automatic run_job(input int n, input int st_from, input int st_len, input int hold,
                         input int rst_at);
    int          u;
    int          nstall;
    int          r;
    logic [15:0] exp_sum;
    logic [7:0]  ew_addr;
    logic        ew_valid;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic        e_en;
    logic        done;
    exp_sum = 16'h0;
    for (int i = 0; i < n; i++) exp_sum = exp_sum + sums[i];
    u = 0; nstall = 0; r = 0; done = 1'b0;
    ew_addr = 8'h0; ew_valid = 1'b0;

    @(negedge clk);
    start = 1'b1; cfg_chunks = 8'(n); stall = 1'b0; res_ready = 1'b0;
    #1 chk("idle_busy", 32'(busy), 32'd0);

    for (int cyc = 1; cyc < n + st_len + hold + 20; cyc++) begin
      @(negedge clk);
      start      = (cyc % 2 == 0);
      cfg_chunks = 8'($urandom);
      stall      = (cyc >= st_from) && (cyc < st_from + st_len);
      res_ready  = 1'($urandom);
      if (cyc == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; stall = 1'b0; res_ready = 1'b0;
        #1 chk_zero("reset_mid_job");
        return;
      end
      if (u >= n + PE_LAT) res_ready = (r >= hold);
      #1;
      chk("busy", 32'(busy), 32'd1);
      chk("wt_addr", 32'(wt_addr), 32'(ew_addr));
      chk("wt_valid", 32'(wt_valid), 32'(ew_valid));
      if (cyc == 1) begin
        chk("clear_pe_clr", 32'(pe_clr), 32'd1);
        chk("clear_pe_en", 32'(pe_en), 32'd1);
        chk("clear_in_valid", 32'(in_valid), 32'd0);
        ew_addr = 8'h0; ew_valid = 1'b0;
      end else if (u < n + PE_LAT) begin
        e_addr  = (u < n) ? 8'(u) : 8'h0;
        e_valid = (u < n);
        e_en    = !stall;
        chk("in_addr", 32'(in_addr), 32'(e_addr));
        if (!stall) chk("in_valid", 32'(in_valid), 32'(e_valid));
        chk("pe_en", 32'(pe_en), 32'(e_en));
        chk("pe_clr", 32'(pe_clr), 32'd0);
        chk("res_valid_early", 32'(res_valid), 32'd0);
        if (e_en) begin
          ew_addr = e_addr; ew_valid = e_valid; u++;
        end else begin
          nstall++;
        end
      end else begin
        if (r == 0) chk("res_cycle", 32'(cyc), 32'(n + 7 + nstall));
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_data", 32'(res_data), 32'(exp_sum));
        chk("res_pe_en", 32'(pe_en), 32'd0);
        r++;
        if (res_ready) begin
          done = 1'b1;
          break;
        end
      end
    end
    if (!done) chk("job_timeout", 32'(done), 32'd1);
    @(negedge clk);
    start = 1'b0; stall = 1'b0; res_ready = 1'b0;
    #1;
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_res_valid", 32'(res_valid), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b1; cfg_chunks = 8'd3; stall = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    rst = 1'b0; start = 1'b0;

    // Single chunk
    sums[0] = 16'h0100;
    run_job(1, 0, 0, 0, 0);

    // Multi chunk
    sums[0] = 16'h0010; sums[1] = 16'h0020; sums[2] = 16'h0030; sums[3] = 16'h0040;
    run_job(4, 0, 0, 0, 0);

    // Stall for cycles 3-4 of an N=3 job
    sums[0] = 16'h1234; sums[1] = 16'h0101; sums[2] = 16'h7000;
    run_job(3, 3, 2, 0, 0);

    // Wrap-around with backpressure; start pulses in RESULT must be ignored
    sums[0] = 16'hFFF0; sums[1] = 16'h0020;
    run_job(2, 0, 0, 5, 0);

    // Reset mid-DRAIN, then a fresh job
    run_job(2, 0, 0, 0, 5);
    sums[0] = 16'h0ABC;
    run_job(1, 0, 0, 0, 0);

    // Zero-length request is ignored
    @(negedge clk);
    start = 1'b1; cfg_chunks = 8'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("zero_busy", 32'(busy), 32'd0);
      chk("zero_pe_en", 32'(pe_en), 32'd0);
    end
    start = 1'b0;

    // Random jobs with random stall windows and backpressure
    for (int j = 0; j < 8; j++) begin
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) sums[i] = 16'($urandom);
      run_job(n, int'($urandom_range(1, 12)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_sched.md
PE_SCHED -- requirements
Module: pe_sched

Interface
REQ-001 SHALL have parameter CHUNK_W, 8, width of chunk count and buffer addresses.
REQ-002 SHALL have parameter PE_LAT, 5, cycles from a PE issue cycle to the matching valid pe_out; fixed at 5 for the 8-lane tree PE.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request one neuron dot-product; sampled only in IDLE.
REQ-006 SHALL have port cfg_chunks  input  CHUNK_W  number of 8-lane chunks; latched on accepted start.
REQ-007 SHALL have port stall  input  1  upstream buffer not ready; freezes the schedule.
REQ-008 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port in_addr  output  CHUNK_W  input-buffer chunk index; combinational-read buffer feeds the PE lanes.
REQ-010 SHALL have port in_valid  output  1  in_addr is meaningful this cycle.
REQ-011 SHALL have port wt_addr  output  CHUNK_W  weight-buffer chunk index, equal to in_addr one enabled cycle earlier.
REQ-012 SHALL have port wt_valid  output  1  wt_addr is meaningful this cycle.
REQ-013 SHALL have port pe_en  output  1  PE register enable.
REQ-014 SHALL have port pe_clr  output  1  PE pipeline synchronous clear.
REQ-015 SHALL have port pe_out  input  16  PE tree-sum result.
REQ-016 SHALL have port res_data  output  16  accumulated neuron sum.
REQ-017 SHALL have port res_valid / res_ready  output / input  1 / 1  result handshake; transfer when both are high.

Function
REQ-018 SHALL implement states IDLE, CLEAR, ISSUE, DRAIN and RESULT.
REQ-019 IDLE: start=1 with cfg_chunks!=0 SHALL latch N=cfg_chunks and go to CLEAR; start with cfg_chunks==0 SHALL be ignored.
REQ-020 CLEAR: for one cycle, pe_clr=1 and pe_en=1, acc SHALL clear to 0 and the tag pipe SHALL clear; next state ISSUE, independent of stall.
REQ-021 ISSUE: for each unstalled cycle, in_addr=k, in_valid=1 and pe_en=1, then k increments; after k=N-1 is issued, next state DRAIN.
REQ-022 wt_addr/wt_valid SHALL be registered copies of in_addr/in_valid, updated only when pe_en=1.
REQ-023 DRAIN: pe_en=1 and in_valid=0 for PE_LAT unstalled cycles, then RESULT.
REQ-024 A PE_LAT-deep valid-tag shift register SHALL advance when ~stall; acc SHALL add pe_out when the tag output is 1 and ~stall.
REQ-025 acc SHALL be 16-bit two's-complement with wrap-around, matching PE arithmetic; no saturation.
REQ-026 stall=1 in ISSUE or DRAIN SHALL force pe_en=0 and freeze k, the drain counter, the tag pipe, acc, wt_addr and wt_valid; in_addr SHALL hold its value.
REQ-027 stall SHALL be ignored in IDLE, CLEAR and RESULT.
REQ-028 RESULT: res_valid=1 and res_data=acc, both held stable until res_ready=1; then next state IDLE. res_ready outside RESULT has no effect.
REQ-029 With no stall, start accepted at cycle 0 SHALL give the first res_valid at cycle N+7.
REQ-030 start while busy SHALL be ignored; cfg_chunks changes after acceptance SHALL have no effect.
REQ-031 pe_clr SHALL be 0 outside CLEAR; pe_en SHALL be 0 in IDLE and RESULT.

Reset
REQ-032 rst=1 SHALL, at the next edge, force state IDLE, k=0, drain counter 0, tag pipe 0, acc 0 and latched N=0.
REQ-033 rst=1 SHALL force every output to 0 (busy, in_addr, in_valid, wt_addr, wt_valid, pe_en, pe_clr, res_data, res_valid), including mid-ISSUE, mid-DRAIN and mid-RESULT.
REQ-034 A pending result SHALL be discarded by reset; the first start after reset SHALL behave as from power-up.

Verification
REQ-035 Single chunk: N=1, PE model returns 0x0100 for chunk 0 -> in_addr=0 at cycle 2, wt_addr=0 at cycle 3, res_valid at cycle 8, res_data=0x0100.
REQ-036 Multi chunk: N=4, chunk sums 0x0010, 0x0020, 0x0030, 0x0040 -> in_addr 0..3 on cycles 2..5, res_valid at cycle 11, res_data=0x00A0.
REQ-037 Stall: N=3, stall=1 for cycles 3-4 -> pe_en=0 and in_addr held at 1 for those cycles, res_valid at cycle 12, sum correct.
REQ-038 Wrap and backpressure: N=2, sums 0xFFF0 and 0x0020 -> res_data=0x0010; with res_ready held 0 for 5 cycles, res_valid and res_data stay stable, and start pulses in that window are ignored.
REQ-039 Reset mid-DRAIN: rst=1 at cycle 5 of an N=2 job -> all outputs 0 next cycle; a fresh N=1 start then completes with the correct sum.
REQ-040 Zero-length request: start with cfg_chunks=0 -> busy stays 0 and pe_en stays 0.
